ram8_arbitro: RTL and testbench

- Two-port arbiter/controller sharing one RAM8 (8 words x 16 bits) between requesters A and B.
- Accepts independent read/write requests, grants one at a time (round-robin), and drives the RAM8 address, write-data and write-enable.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between two datapath masters and the RAM8 instance.

---
 rtl/ram8_arbitro.sv | 131 +++++++++++++
 tb/tb_ram8_arbitro.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram8_arbitro.sv
// ram8_arbitro: two-port arbiter/controller sharing one RAM8 (8 x 16 bit)
// between requesters A and B. One access is granted at a time. The default
// policy is round-robin on ties.
//
// Build option: define ARB_PRIORIDADE_FIXA_EN for fixed priority. With it,
// A always wins a tie and no "last served" register exists. B can starve
// while A requests back-to-back.
//
// Ports:
//   clk, reset_n              clock; asynchronous active-low reset
//   req_<p>, we_<p>           request (held until ack), 1 = write / 0 = read
//   end_<p>, dado_<p>         address and write data of requester <p>
//   ack_<p>                   one-cycle pulse when the access of <p> completes
//   saida_<p>                 read data of <p>, valid while ack_<p> = 1
//   ram_endereco              RAM8 address (holds last latched value)
//   ram_dados_entrada         RAM8 write data (holds last latched value)
//   ram_enable                RAM8 write strobe, high only in ACESSO for writes
//   ram_dados_saida           RAM8 combinational read data of ram_endereco
//
// Access sequence: OCIOSO (grant + latch) -> ACESSO (RAM cycle) ->
// RESPOSTA (ack). This gives at most one access every three cycles.
module ram8_arbitro #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] end_a,
    input  logic [DATA_W-1:0] dado_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] saida_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] end_b,
    input  logic [DATA_W-1:0] dado_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] saida_b,
    output logic [ADDR_W-1:0] ram_endereco,
    output logic [DATA_W-1:0] ram_dados_entrada,
    output logic              ram_enable,
    input  logic [DATA_W-1:0] ram_dados_saida
);

    typedef enum logic [1:0] {
        OCIOSO,
        ACESSO,
        RESPOSTA
    } estado_t;

    estado_t estado;
    logic    we_reg;     // latched write flag of the granted access
    logic    sel;        // granted requester: 0 = A, 1 = B
    logic    ganha_b;    // B wins the grant at this OCIOSO sample

`ifdef ARB_PRIORIDADE_FIXA_EN
    always_comb ganha_b = req_b & ~req_a;
`else
    logic    ultimo;     // last served requester: 0 = A, 1 = B

    // On a tie, the requester that was not served last wins.
    always_comb ganha_b = req_b & (~req_a | ~ultimo);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado            <= OCIOSO;
            we_reg            <= 1'b0;
            sel               <= 1'b0;
            ack_a             <= 1'b0;
            ack_b             <= 1'b0;
            saida_a           <= '0;
            saida_b           <= '0;
            ram_endereco      <= '0;
            ram_dados_entrada <= '0;
            ram_enable        <= 1'b0;
`ifndef ARB_PRIORIDADE_FIXA_EN
            ultimo            <= 1'b1;   // A wins the first tie
`endif
        end else begin
            case (estado)
                OCIOSO: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (req_a || req_b) begin
                        sel <= ganha_b;
                        if (ganha_b) begin
                            we_reg            <= we_b;
                            ram_endereco      <= end_b;
                            ram_dados_entrada <= dado_b;
                            ram_enable        <= we_b;
                        end else begin
                            we_reg            <= we_a;
                            ram_endereco      <= end_a;
                            ram_dados_entrada <= dado_a;
                            ram_enable        <= we_a;
                        end
                        estado <= ACESSO;
                    end
                end
                ACESSO: begin
                    // Read data is sampled on the edge that closes the RAM cycle.
                    if (!we_reg) begin
                        if (sel) saida_b <= ram_dados_saida;
                        else     saida_a <= ram_dados_saida;
                    end
`ifndef ARB_PRIORIDADE_FIXA_EN
                    ultimo     <= sel;
`endif
                    ram_enable <= 1'b0;
                    ack_a      <= ~sel;
                    ack_b      <= sel;
                    estado     <= RESPOSTA;
                end
                RESPOSTA: begin
                    ack_a  <= 1'b0;
                    ack_b  <= 1'b0;
                    estado <= OCIOSO;
                end
                default: begin
                    ack_a      <= 1'b0;
                    ack_b      <= 1'b0;
                    ram_enable <= 1'b0;
                    estado     <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_arbitro.sv
// Testbench for ram8_arbitro. It contains a RAM8 stub and a transaction-level
// reference model: a memory image, the last served requester and the expected
// read data of each port.
module tb_ram8_arbitro;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] end_a, end_b;
    logic [DATA_W-1:0] dado_a, dado_b;
    logic              ack_a, ack_b;
    logic [DATA_W-1:0] saida_a, saida_b;
    logic [ADDR_W-1:0] ram_endereco;
    logic [DATA_W-1:0] ram_dados_entrada;
    logic              ram_enable;
    logic [DATA_W-1:0] ram_dados_saida;

    always #5 clk = ~clk;

    ram8_arbitro #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_a            (req_a),
        .we_a             (we_a),
        .end_a            (end_a),
        .dado_a           (dado_a),
        .ack_a            (ack_a),
        .saida_a          (saida_a),
        .req_b            (req_b),
        .we_b             (we_b),
        .end_b            (end_b),
        .dado_b           (dado_b),
        .ack_b            (ack_b),
        .saida_b          (saida_b),
        .ram_endereco     (ram_endereco),
        .ram_dados_entrada(ram_dados_entrada),
        .ram_enable       (ram_enable),
        .ram_dados_saida  (ram_dados_saida)
    );

    // RAM8 stub: combinational read, write on the rising edge when enabled.
    logic [DATA_W-1:0] ram [8] = '{default: '0};
    assign ram_dados_saida = ram[ram_endereco];
    always @(posedge clk) if (ram_enable) ram[ram_endereco] <= ram_dados_entrada;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [8] = '{default: '0};
    logic [DATA_W-1:0] exp_saida [2];
    bit                last;          // last served requester: 0 = A, 1 = B
    bit                order_q [$];   // served requesters, in order

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input bit ra, input bit rb);
        if (ra && !rb) return 1'b0;
        if (rb && !ra) return 1'b1;
`ifdef ARB_PRIORIDADE_FIXA_EN
        return 1'b0;
`else
        return ~last;
`endif
    endfunction

    task automatic model_reset();
        last         = 1'b1;
        exp_saida[0] = '0;
        exp_saida[1] = '0;
    endtask

    // Serve n accesses from the currently driven requests. The call starts
    // with the DUT idle, between clock edges. On ack, the served port drops
    // req. With rearm, that port raises req again for the next idle sample.
    task automatic serve(input int n, input bit rearm, input bit scramble);
        bit                w, we_w;
        logic [ADDR_W-1:0] ad_w;
        logic [DATA_W-1:0] dd_w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            w    = pick(req_a, req_b);
            we_w = w ? we_b : we_a;
            ad_w = w ? end_b : end_a;
            dd_w = w ? dado_b : dado_a;
            #1;
            check("acesso_enable", ram_enable, we_w);
            check("acesso_endereco", ram_endereco, ad_w);
            check("acesso_dados", ram_dados_entrada, dd_w);
            check("acesso_acks", {ack_a, ack_b}, 2'b00);
            if (scramble) begin
                if (w) begin we_b = $urandom; end_b = $urandom; dado_b = $urandom; end
                else   begin we_a = $urandom; end_a = $urandom; dado_a = $urandom; end
            end
            @(posedge clk);
            if (we_w) ref_mem[ad_w] = dd_w;
            else      exp_saida[w]  = ref_mem[ad_w];
            last = w;
            order_q.push_back(w);
            #1;
            check("resposta_acks", {ack_a, ack_b}, w ? 2'b01 : 2'b10);
            check("resposta_enable", ram_enable, 1'b0);
            check("resposta_saida_a", saida_a, exp_saida[0]);
            check("resposta_saida_b", saida_b, exp_saida[1]);
            check("resposta_endereco", ram_endereco, ad_w);
            if (w) req_b = 1'b0; else req_a = 1'b0;
            @(posedge clk); #1;
            check("ocioso_acks", {ack_a, ack_b}, 2'b00);
            check("ocioso_enable", ram_enable, 1'b0);
            if (rearm) begin
                if (w) req_b = 1'b1; else req_a = 1'b1;
            end
        end
    endtask

    initial begin
        bit ra, rb;
        req_a = 0; we_a = 0; end_a = '0; dado_a = '0;
        req_b = 0; we_b = 0; end_b = '0; dado_b = '0;
        reset_n = 1'b0;
        model_reset();
        #12;
        check("reset_acks", {ack_a, ack_b}, 2'b00);
        check("reset_saida_a", saida_a, 16'h0000);
        check("reset_saida_b", saida_b, 16'h0000);
        check("reset_endereco", ram_endereco, 3'd0);
        check("reset_dados", ram_dados_entrada, 16'h0000);
        check("reset_enable", ram_enable, 1'b0);
        @(negedge clk) reset_n = 1'b1;

        // Write A only, then read back through B
        req_a = 1; we_a = 1; end_a = 3'd3; dado_a = 16'hAAAA;
        serve(1, 0, 0);
        req_b = 1; we_b = 0; end_b = 3'd3; dado_b = 16'h5555;
        serve(1, 0, 0);
        check("readback_b", saida_b, 16'hAAAA);

        // Simultaneous writes right after reset: A first, then B
        @(negedge clk) reset_n = 1'b0;
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        order_q.delete();
        req_a = 1; we_a = 1; end_a = 3'd1; dado_a = 16'h1111;
        req_b = 1; we_b = 1; end_b = 3'd2; dado_b = 16'h2222;
        serve(2, 0, 0);
        check("tie_first_a", order_q[0], 1'b0);
        check("tie_second_b", order_q[1], 1'b1);
        req_a = 1; we_a = 0; end_a = 3'd1;
        serve(1, 0, 0);
        check("read_end1", saida_a, 16'h1111);
        req_b = 1; we_b = 0; end_b = 3'd2;
        serve(1, 0, 0);
        check("read_end2", saida_b, 16'h2222);

        // Fairness: both requests are held continuously for 6 accesses
        order_q.delete();
        req_a = 1; we_a = 0; end_a = 3'd3;
        req_b = 1; we_b = 0; end_b = 3'd1;
        serve(6, 1, 0);
        req_a = 0; req_b = 0;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_PRIORIDADE_FIXA_EN
            check("fixa_order", order_q[i], 1'b0);
`else
            check("rr_order", order_q[i], i % 2);
`endif
        end

        // Asynchronous reset during ACESSO of a write. The write data equals
        // the stored word, so whether the write commits does not matter.
        req_a = 1; we_a = 1; end_a = 3'd5; dado_a = ref_mem[5];
        @(posedge clk); #1;
        check("midreset_enable_before", ram_enable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_enable", ram_enable, 1'b0);
        check("midreset_acks", {ack_a, ack_b}, 2'b00);
        check("midreset_saida_a", saida_a, 16'h0000);
        check("midreset_endereco", ram_endereco, 3'd0);
        req_a = 0;
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        req_a = 1; we_a = 0; end_a = 3'd5;
        serve(1, 0, 0);

        // Random traffic. Fields of the granted port are sometimes changed mid-access.
        for (int k = 0; k < 24; k++) begin
            ra = $urandom; rb = $urandom;
            if (!ra && !rb) ra = 1'b1;
            req_a = ra; we_a = $urandom; end_a = $urandom; dado_a = $urandom;
            req_b = rb; we_b = $urandom; end_b = $urandom; dado_b = $urandom;
            serve(int'(ra) + int'(rb), 0, bit'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
